// File: rtl/ca_rx_align_pkg.sv
// ca_rx_align_pkg: FSM state type and marker-check helpers shared by the aligner
package ca_rx_align_pkg;
  localparam int MAX_CH = 24;
  typedef enum logic [1:0] {IDLE, WAIT_MARK, ALIGNED, ERROR} align_state_t;
  // every active channel presents a marked head; inactive lanes are don't-care
  function automatic logic all_marked(input logic [MAX_CH-1:0] marks, input logic [MAX_CH-1:0] act);
    return &(marks | ~act);
  endfunction
  // the active channels disagree on the marker bit
  function automatic logic mixed_marks(input logic [MAX_CH-1:0] marks, input logic [MAX_CH-1:0] act);
    return (|(marks & act)) && (|(~marks & act));
  endfunction
endpackage

// File: rtl/ca_rx_align_ch_fifo.sv
// ca_rx_align_ch_fifo: single-channel circular buffer with occupancy count
module ca_rx_align_ch_fifo #(
  parameter int W = 81,
  parameter int AD_WIDTH = 4
) (
  input  logic com_clk,
  input  logic rst_com,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AD_WIDTH:0] numfilled
);
  localparam int DEPTH = 1 << AD_WIDTH;
  localparam int NW = AD_WIDTH + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AD_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [AD_WIDTH:0] r_numfilled;
  // storage carries no reset; its contents are qualified by the count
  always_ff @(posedge com_clk) if (push) r_mem[r_wr_ptr] <= wdata;
  // pointers wrap naturally at DEPTH; flush empties the buffer in one cycle
  always_ff @(posedge com_clk or posedge rst_com) begin
    if (rst_com) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_numfilled <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_numfilled <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AD_WIDTH'(push);
      r_rd_ptr <= r_rd_ptr + AD_WIDTH'(pop);
      r_numfilled <= r_numfilled + NW'(push) - NW'(pop);
    end
  end
  assign rdata = r_mem[r_rd_ptr];
  assign numfilled = r_numfilled;
endmodule

// File: rtl/ca_rx_align_buf.sv
// ca_rx_align_buf: per-channel receive FIFOs deskewed on a common alignment marker
module ca_rx_align_buf
  import ca_rx_align_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int BITS_PER_CHANNEL = 80,
  parameter int AD_WIDTH = 4
) (
  input  logic com_clk,
  input  logic rst_com,
  input  logic align_en,
  input  logic [NUM_CH-1:0] fifo_push,
  input  logic [NUM_CH*BITS_PER_CHANNEL-1:0] rx_din,
  input  logic [NUM_CH-1:0] rx_mark,
  output logic [NUM_CH*BITS_PER_CHANNEL-1:0] rx_dout,
  output logic rx_dout_vld,
  output logic align_done,
  output logic align_err,
  input  logic [AD_WIDTH:0] fifo_full_val,
  input  logic [AD_WIDTH:0] fifo_pfull_val,
  input  logic [AD_WIDTH:0] fifo_pempty_val,
  output logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] fifo_pfull,
  output logic [NUM_CH-1:0] fifo_empty,
  output logic [NUM_CH-1:0] fifo_pempty,
  output logic [NUM_CH-1:0] overflow_sticky
);
  localparam int BPC = BITS_PER_CHANNEL;
  localparam int NW = AD_WIDTH + 1;
  localparam logic [AD_WIDTH:0] DEPTH_V = NW'(1 << AD_WIDTH);
  align_state_t r_state, w_state_nxt;
  logic [NUM_CH-1:0] w_head_mark, w_nonempty, w_at_depth, w_pop, w_wr, w_drop;
  logic [NUM_CH*BPC-1:0] w_head_data;
  logic [MAX_CH-1:0] w_act, w_live_marks, w_head_marks;
  logic w_flush, w_push_en, w_pop_all;
  logic [NUM_CH*BPC-1:0] r_dout;
  logic r_vld, r_done, r_err;
  logic [NUM_CH-1:0] r_ovf;
  assign w_act = MAX_CH'({NUM_CH{1'b1}});
  assign w_head_marks = MAX_CH'(w_head_mark);
  assign w_live_marks = MAX_CH'(w_head_mark & w_nonempty);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [BPC:0] w_rdata;
    logic [AD_WIDTH:0] w_nf;
    ca_rx_align_ch_fifo #(.W(BPC + 1), .AD_WIDTH(AD_WIDTH)) u_fifo (
      .com_clk(com_clk),
      .rst_com(rst_com),
      .push(w_wr[c]),
      .pop(w_pop[c]),
      .flush(w_flush),
      .wdata({rx_mark[c], rx_din[c*BPC +: BPC]}),
      .rdata(w_rdata),
      .numfilled(w_nf)
    );
    assign w_head_mark[c] = w_rdata[BPC];
    assign w_head_data[c*BPC +: BPC] = w_rdata[BPC-1:0];
    assign w_nonempty[c] = w_nf != '0;
    assign w_at_depth[c] = w_nf == DEPTH_V;
    assign w_wr[c] = w_push_en && fifo_push[c] && (w_nf != DEPTH_V || w_pop[c]);
    assign w_drop[c] = w_push_en && fifo_push[c] && !w_wr[c];
    assign fifo_full[c] = w_nf >= fifo_full_val;
    assign fifo_pfull[c] = w_nf >= fifo_pfull_val;
    assign fifo_empty[c] = w_nf == '0;
    assign fifo_pempty[c] = w_nf <= fifo_pempty_val;
  end
  // state register
  always_ff @(posedge com_clk or posedge rst_com) begin
    if (rst_com) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // next state: disable wins, hunt until every head is marked, lock until marks disagree
  always_comb begin
    w_state_nxt = !align_en ? IDLE :
                  r_state == IDLE ? WAIT_MARK :
                  r_state == WAIT_MARK ? (all_marked(w_live_marks, w_act) ? ALIGNED :
                                          (|w_at_depth) ? ERROR : WAIT_MARK) :
                  r_state == ALIGNED ? ((w_pop_all && mixed_marks(w_head_marks, w_act)) ? ERROR : ALIGNED) :
                  ERROR;
  end
  // FIFO control: flush when leaving for IDLE, drop unmarked heads while hunting, pop groups when locked
  always_comb begin
    w_flush = r_state != IDLE && !align_en;
    w_push_en = r_state != IDLE && align_en;
    w_pop_all = r_state == ALIGNED && align_en && (&w_nonempty);
    w_pop = w_pop_all ? {NUM_CH{1'b1}} :
            (r_state == WAIT_MARK && align_en) ? (w_nonempty & ~w_head_mark) : '0;
  end
  // registered outputs; status flags track the state being entered
  always_ff @(posedge com_clk or posedge rst_com) begin
    if (rst_com) begin
      r_dout <= '0;
      r_vld <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_ovf <= '0;
    end else begin
      r_vld <= w_pop_all;
      if (w_pop_all) r_dout <= w_head_data;
      r_done <= w_state_nxt == ALIGNED;
      r_err <= w_state_nxt == ERROR;
      r_ovf <= w_flush ? '0 : (r_ovf | w_drop);
    end
  end
  assign rx_dout = r_dout;
  assign rx_dout_vld = r_vld;
  assign align_done = r_done;
  assign align_err = r_err;
  assign overflow_sticky = r_ovf;
endmodule

// File: tb/tb_ca_rx_align_buf.sv
// tb_ca_rx_align_buf: directed stimulus checked against a queue-based model of the aligner
module tb_ca_rx_align_buf;
  localparam int NUM_CH = 2;
  localparam int BPC = 80;
  localparam int AD = 4;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0;
  localparam int M_HUNT = 1;
  localparam int M_LOCK = 2;
  localparam int M_FAIL = 3;
  typedef logic [BPC:0] ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [NUM_CH-1:0] push = '0;
  logic [NUM_CH-1:0] mark = '0;
  logic [NUM_CH*BPC-1:0] din = '0;
  logic [AD:0] full_val = 5'd16;
  logic [AD:0] pfull_val = 5'd12;
  logic [AD:0] pempty_val = 5'd2;
  logic [NUM_CH*BPC-1:0] dout;
  logic vld, done, err;
  logic [NUM_CH-1:0] full, pfull, empty, pempty, ovf;
  ent_t q[NUM_CH][$];
  int mode = M_IDLE;
  logic e_vld = 1'b0;
  logic [NUM_CH*BPC-1:0] e_dout = '0;
  logic [NUM_CH-1:0] e_ovf = '0;
  logic [NUM_CH-1:0] ef, epf, ee, epe;
  int n_vec = 0;
  int n_err = 0;

  ca_rx_align_buf #(.NUM_CH(NUM_CH), .BITS_PER_CHANNEL(BPC), .AD_WIDTH(AD)) dut (
    .com_clk(clk), .rst_com(rst), .align_en(en), .fifo_push(push), .rx_din(din), .rx_mark(mark),
    .rx_dout(dout), .rx_dout_vld(vld), .align_done(done), .align_err(err),
    .fifo_full_val(full_val), .fifo_pfull_val(pfull_val), .fifo_pempty_val(pempty_val),
    .fifo_full(full), .fifo_pfull(pfull), .fifo_empty(empty), .fifo_pempty(pempty),
    .overflow_sticky(ovf)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] pop;
    int nm;
    bit allm, anyf, allne, any1, any0;
    ent_t h;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) q[c].delete();
      mode = M_IDLE;
      e_vld = 1'b0;
      e_dout = '0;
      e_ovf = '0;
      return;
    end
    pop = '0;
    nm = mode;
    e_vld = 1'b0;
    if (!en) begin
      if (mode != M_IDLE) begin
        for (int c = 0; c < NUM_CH; c++) q[c].delete();
        e_ovf = '0;
      end
      nm = M_IDLE;
    end else if (mode == M_IDLE) begin
      nm = M_HUNT;
    end else begin
      allm = 1; anyf = 0; allne = 1; any1 = 0; any0 = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        allne &= (q[c].size() > 0);
        anyf |= (q[c].size() == DEPTH);
        if (q[c].size() > 0) begin
          h = q[c][0];
          allm &= h[BPC];
        end else allm = 0;
      end
      if (mode == M_HUNT) begin
        for (int c = 0; c < NUM_CH; c++)
          if (q[c].size() > 0) begin
            h = q[c][0];
            pop[c] = !h[BPC];
          end
        nm = allm ? M_LOCK : anyf ? M_FAIL : M_HUNT;
      end else if (mode == M_LOCK && allne) begin
        pop = '1;
        e_vld = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          h = q[c][0];
          e_dout[c*BPC +: BPC] = h[BPC-1:0];
          any1 |= h[BPC];
          any0 |= !h[BPC];
        end
        if (any1 && any0) nm = M_FAIL;
      end
      for (int c = 0; c < NUM_CH; c++) if (pop[c]) void'(q[c].pop_front());
      for (int c = 0; c < NUM_CH; c++)
        if (push[c]) begin
          if (q[c].size() < DEPTH) q[c].push_back({mark[c], din[c*BPC +: BPC]});
          else e_ovf[c] = 1'b1;
        end
    end
    mode = nm;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      ef[c] = q[c].size() >= int'(full_val);
      epf[c] = q[c].size() >= int'(pfull_val);
      ee[c] = q[c].size() == 0;
      epe[c] = q[c].size() <= int'(pempty_val);
    end
    chk("dout_vld", vld, e_vld);
    chk("dout", dout, e_dout);
    chk("align_done", done, mode == M_LOCK);
    chk("align_err", err, mode == M_FAIL);
    chk("overflow", ovf, e_ovf);
    chk("full", full, ef);
    chk("pfull", pfull, epf);
    chk("empty", empty, ee);
    chk("pempty", pempty, epe);
  end

  task automatic send(input logic [NUM_CH-1:0] p, input logic [NUM_CH-1:0] m,
                      input logic [BPC-1:0] d0, input logic [BPC-1:0] d1);
    push = p;
    mark = m;
    din = {d1, d0};
    @(negedge clk);
    push = '0;
    mark = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [NUM_CH*BPC-1:0] xd;
    idle(2);
    chk("rst_done", done, 0);
    chk("rst_vld", vld, 0);
    chk("rst_empty", empty, 2'b11);
    rst = 1'b0;
    en = 1'b1;
    idle(1);
    send(2'b11, 2'b10, 80'h101, 80'hB0);
    send(2'b01, 2'b00, 80'h102, 80'h0);
    send(2'b01, 2'b00, 80'h103, 80'h0);
    send(2'b01, 2'b01, 80'hA0, 80'h0);
    chk("hunt_done", done, 0);
    idle(1);
    chk("lock_done", done, 1);
    chk("lock_vld", vld, 0);
    idle(1);
    xd = {80'hB0, 80'hA0};
    chk("pair_vld", vld, 1);
    chk("pair_dout", dout, xd);
    idle(1);
    chk("hold_vld", vld, 0);
    chk("hold_dout", dout, xd);
    send(2'b11, 2'b00, 80'h201, 80'h301);
    chk("lat_vld0", vld, 0);
    idle(1);
    xd = {80'h301, 80'h201};
    chk("lat_vld1", vld, 1);
    chk("lat_dout", dout, xd);
    send(2'b11, 2'b01, 80'h401, 80'h501);
    chk("mix_err0", err, 0);
    idle(1);
    xd = {80'h501, 80'h401};
    chk("mix_vld", vld, 1);
    chk("mix_dout", dout, xd);
    chk("mix_err", err, 1);
    chk("mix_done", done, 0);
    idle(1);
    chk("err_stay", err, 1);
    en = 1'b0;
    idle(1);
    chk("flush_err", err, 0);
    chk("flush_empty", empty, 2'b11);
    en = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) send(2'b01, 2'b00, 80'(i), 80'h0);
    chk("drain_done", done, 0);
    chk("drain_ch1_empty", empty[1], 1);
    for (int i = 0; i < 16; i++) send(2'b01, 2'b01, 80'(32'h600 + i), 80'h0);
    chk("depth_full", full[0], 1);
    chk("depth_model", q[0].size(), 16);
    chk("depth_err0", err, 0);
    idle(1);
    chk("depth_err1", err, 1);
    en = 1'b0;
    idle(1);
    en = 1'b1;
    idle(1);
    send(2'b11, 2'b11, 80'h700, 80'h701);
    idle(2);
    chk("relock_done", done, 1);
    chk("relock_vld", vld, 1);
    for (int i = 0; i <= 16; i++) begin
      chk("sweep_pempty", pempty[0], i <= 2);
      chk("sweep_pfull", pfull[0], i >= 12);
      chk("sweep_full", full[0], i >= 16);
      chk("sweep_ovf", ovf, 2'b00);
      if (i < 16) send(2'b01, 2'b00, 80'(32'h800 + i), 80'h0);
    end
    send(2'b01, 2'b00, 80'h8FF, 80'h0);
    chk("ovf_set", ovf, 2'b01);
    chk("ovf_full", full, 2'b01);
    chk("ovf_model", q[0].size(), 16);
    en = 1'b0;
    idle(1);
    chk("ovf_clear", ovf, 2'b00);
    en = 1'b1;
    idle(1);
    send(2'b11, 2'b11, 80'h900, 80'h901);
    idle(2);
    chk("pre_rst_vld", vld, 1);
    for (int i = 0; i < 5; i++) send(2'b01, 2'b00, 80'(32'h910 + i), 80'h0);
    chk("pre_rst_buf", empty[0], 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", vld, 0);
    chk("arst_done", done, 0);
    chk("arst_dout", dout, 0);
    chk("arst_empty", empty, 2'b11);
    chk("arst_pfull", pfull, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("post_rst_vld", vld, 0);
    end
    send(2'b11, 2'b11, 80'hA00, 80'hA01);
    idle(1);
    chk("post_rst_done", done, 1);
    idle(1);
    xd = {80'hA01, 80'hA00};
    chk("post_rst_vld1", vld, 1);
    chk("post_rst_dout", dout, xd);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
